// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, SIPO shift control, parity/stop checking
// and a one-cycle result strobe, all clocked by the baud tick.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Baud_Clk,
  input  logic                 Reset,
  input  logic                 Rx_In,
  input  logic                 Rx_En,
  input  logic [31:0]          Sipo_data,
  output logic                 Shift1,
  output logic [DATA_BITS-1:0] Rx_word,
  output logic                 Rx_valid,
  output logic                 Parity_err,
  output logic                 Frame_err,
  output logic                 Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [5:0] LAST_BIT  = 6'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               r_state;
  logic [5:0]           r_cnt;
  logic                 r_par;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_stop_cnt;
  logic                 r_shift;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [5:0]           w_cnt_nxt;
  logic                 w_par_nxt;
  logic                 w_perr_nxt;
  logic                 w_ferr_nxt;
  logic                 w_stop_nxt;
  logic                 w_shift_nxt;
  logic [DATA_BITS-1:0] w_word_nxt;
  logic                 w_valid_nxt;
  logic                 w_parity_err_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_ferr_now;

  // Only the top DATA_BITS of the SIPO ever hold frame data.
  logic w_sipo_unused;
  assign w_sipo_unused = ^Sipo_data;

  always_ff @(posedge Baud_Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= 1'b0;
      r_word       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_par        <= w_par_nxt;
      r_perr       <= w_perr_nxt;
      r_ferr       <= w_ferr_nxt;
      r_stop_cnt   <= w_stop_nxt;
      r_shift      <= w_shift_nxt;
      r_word       <= w_word_nxt;
      r_valid      <= w_valid_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_par_nxt        = r_par;
    w_perr_nxt       = r_perr;
    w_ferr_nxt       = r_ferr;
    w_stop_nxt       = r_stop_cnt;
    w_shift_nxt      = r_shift;
    w_word_nxt       = r_word;
    w_valid_nxt      = 1'b0;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = r_frame_err;
    w_ferr_now       = r_ferr | ~Rx_In;

    // Dropping the enable abandons the frame; the SIPO is left as it stands.
    if ((r_state != S_IDLE) && !Rx_En) begin
      w_state_nxt = S_IDLE;
      w_shift_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Rx_En && !Rx_In) begin
            w_state_nxt = S_DATA;
            w_shift_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_par_nxt   = 1'(PARITY_ODD);
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
            w_stop_nxt  = 1'b0;
          end
        end
        S_DATA: begin
          w_par_nxt = r_par ^ Rx_In;
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == LAST_BIT) begin
            w_shift_nxt = 1'b0;
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          w_perr_nxt  = r_par ^ Rx_In;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_ferr_nxt = w_ferr_now;
          if (r_stop_cnt == LAST_STOP) begin
            w_word_nxt       = Sipo_data[31 -: DATA_BITS];
            w_parity_err_nxt = r_perr;
            w_frame_err_nxt  = w_ferr_now;
            w_valid_nxt      = 1'b1;
            w_state_nxt      = Rx_In ? S_IDLE : S_BREAK;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
        S_BREAK: begin
          if (Rx_In) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_shift_nxt = 1'b0;
        end
      endcase
    end
  end

  assign Shift1     = r_shift;
  assign Rx_word    = r_word;
  assign Rx_valid   = r_valid;
  assign Parity_err = r_parity_err;
  assign Frame_err  = r_frame_err;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a default 8E1 instance and a 32-bit, no-parity,
// two-stop-bit instance, each feeding a behavioural right-shifting SIPO.
module tb_uart_rx_ctrl;

  typedef struct packed {
    logic [31:0] word;
    logic        perr;
    logic        ferr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_a = 1'b1, en_a = 1'b1;
  logic        rx_b = 1'b1, en_b = 1'b1;
  logic [31:0] sipo_a = '0, sipo_b = '0;
  logic        shift_a, valid_a, perr_a, ferr_a, busy_a;
  logic        shift_b, valid_b, perr_b, ferr_b, busy_b;
  logic [7:0]  word_a;
  logic [31:0] word_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   sh_a = 0, sh_b = 0;
  int   t_va_prev = 0, t_va_last = 0;
  int   t_fall_b = 0;
  logic prev_valid_a = 1'b0, prev_valid_b = 1'b0, prev_shift_b = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl u_dut_a (
    .Baud_Clk(clk), .Reset(rst_n), .Rx_In(rx_a), .Rx_En(en_a), .Sipo_data(sipo_a),
    .Shift1(shift_a), .Rx_word(word_a), .Rx_valid(valid_a), .Parity_err(perr_a),
    .Frame_err(ferr_a), .Busy(busy_a)
  );

  uart_rx_ctrl #(.DATA_BITS(32), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
    .Baud_Clk(clk), .Reset(rst_n), .Rx_In(rx_b), .Rx_En(en_b), .Sipo_data(sipo_b),
    .Shift1(shift_b), .Rx_word(word_b), .Rx_valid(valid_b), .Parity_err(perr_b),
    .Frame_err(ferr_b), .Busy(busy_b)
  );

  // External SIPOs: first line bit ends up in the lowest used position.
  always @(posedge clk) begin
    if (shift_a) sipo_a <= {rx_a, sipo_a[31:1]};
    if (shift_b) sipo_b <= {rx_b, sipo_b[31:1]};
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result strobe is seen.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (valid_a) begin
      check("valid_a_one_cycle", prev_valid_a, 1'b0);
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL valid_a_unexpected: got strobe, expected none (word %0h)", word_a);
      end else begin
        e = q_a.pop_front();
        check("word_a", {24'd0, word_a}, e.word);
        check("perr_a", perr_a, e.perr);
        check("ferr_a", ferr_a, e.ferr);
        check("shift_edges_a", sh_a, 8);
      end
      t_va_prev = t_va_last;
      t_va_last = cyc;
      sh_a = 0;
    end else if (!busy_a) sh_a = 0;
    else if (shift_a) sh_a++;
    prev_valid_a = valid_a;

    if (prev_shift_b && !shift_b) t_fall_b = cyc;
    if (valid_b) begin
      check("valid_b_one_cycle", prev_valid_b, 1'b0);
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL valid_b_unexpected: got strobe, expected none (word %0h)", word_b);
      end else begin
        e = q_b.pop_front();
        check("word_b", word_b, e.word);
        check("perr_b", perr_b, e.perr);
        check("ferr_b", ferr_b, e.ferr);
        check("shift_edges_b", sh_b, 32);
        check("latency_b", cyc - t_fall_b, 2);
      end
      sh_b = 0;
    end else if (!busy_b) sh_b = 0;
    else if (shift_b) sh_b++;
    prev_valid_b = valid_b;
    prev_shift_b = shift_b;
  end

  task automatic send_bit(input int which, input logic b);
    if (which == 0) rx_a = b;
    else rx_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame_a(input logic [7:0] w, input logic pbit, input logic sbit,
                              input logic eperr, input logic eferr);
    q_a.push_back('{word: {24'd0, w}, perr: eperr, ferr: eferr});
    send_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(0, w[i]);
    send_bit(0, pbit);
    send_bit(0, sbit);
  endtask

  task automatic send_frame_b(input logic [31:0] w, input logic s1, input logic s2,
                              input logic eferr);
    q_b.push_back('{word: w, perr: 1'b0, ferr: eferr});
    send_bit(1, 1'b0);
    for (int i = 0; i < 32; i++) send_bit(1, w[i]);
    send_bit(1, s1);
    send_bit(1, s2);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_shift", shift_a, 1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_perr", perr_a, 1'b0);
    check("rst_ferr", ferr_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_word", {24'd0, word_a}, 32'd0);
    check("rst_word_b", word_b, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Clean 8E1 frame, then the same frame with a bad parity bit.
    send_frame_a(8'h4A, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame_a(8'h4A, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("perr_held", perr_a, 1'b1);

    // Stop bit low followed by a held break; no start may be taken while low.
    send_frame_a(8'h4A, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_bit(0, 1'b0);
      check("break_busy", busy_a, 1'b1);
      check("break_no_shift", shift_a, 1'b0);
    end
    send_bit(0, 1'b1);
    check("break_exit_busy", busy_a, 1'b0);
    idle(2);
    check("ferr_held", ferr_a, 1'b1);

    // Asynchronous reset in the middle of data bit 4.
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    rx_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_shift", shift_a, 1'b0);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_valid", valid_a, 1'b0);
    check("midrst_ferr", ferr_a, 1'b0);
    check("midrst_word", {24'd0, word_a}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    send_frame_a(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Back-to-back frames with no idle gap.
    send_frame_a(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame_a(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("b2b_spacing", t_va_last - t_va_prev, 11);

    // Enable dropped mid-frame: frame abandoned with no strobe.
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    en_a = 1'b0;
    send_bit(0, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    check("abort_shift", shift_a, 1'b0);
    idle(2);
    en_a = 1'b1;
    idle(2);

    // 32-bit, no parity, two stop bits; second frame has a low first stop bit.
    send_frame_b(32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    idle(2);
    send_frame_b(32'h80000001, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("ferr_b_held", ferr_b, 1'b1);
    check("perr_b_zero", perr_b, 1'b0);

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
